// File: rtl/mem_access_pkg.sv
// mem_access_pkg: op codes, FSM states, lane-select constants and small decode helpers
// for the memory-stage load/store controller. The optional misaligned-access trap is
// enabled by defining MEM_MISALIGN_EXC_EN; these helpers serve both builds.
package mem_access_pkg;

    // Request op codes; bit 3 marks a store, bits [1:0] encode the access size.
    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LH  = 4'h1;
    localparam logic [3:0] OP_LW  = 4'h2;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;

    // Access size encodings found in op[1:0] of every legal op.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWait   = 2'd2
    } state_t;

    // Byte-lane enables.
    localparam logic [3:0] SEL_B0  = 4'b0001;
    localparam logic [3:0] SEL_B1  = 4'b0010;
    localparam logic [3:0] SEL_B2  = 4'b0100;
    localparam logic [3:0] SEL_B3  = 4'b1000;
    localparam logic [3:0] SEL_HLO = 4'b0011;
    localparam logic [3:0] SEL_HHI = 4'b1100;
    localparam logic [3:0] SEL_W   = 4'b1111;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: ok = 1'b1;
            default:                                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only meaningful for legal ops.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic mis;
        case (op[1:0])
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = |lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Force the low address bits to the natural alignment of the access size.
    function automatic logic [1:0] align_lo(input logic [3:0] op, input logic [1:0] lo);
        logic [1:0] res;
        case (op[1:0])
            SZ_HALF: res = {lo[1], 1'b0};
            SZ_WORD: res = 2'b00;
            default: res = lo;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational lane steering. From the op and the low address
// bits it derives the RAM byte-lane enables, replicates store data onto every lane and
// sign/zero-extends the right-justified load data returned by the RAM.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    // Byte-lane enables from access size and address offset.
    always_comb begin
        sel = 4'b0000;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                case (addr_lo)
                    2'd0:    sel = SEL_B0;
                    2'd1:    sel = SEL_B1;
                    2'd2:    sel = SEL_B2;
                    default: sel = SEL_B3;
                endcase
            end
            OP_LH, OP_LHU, OP_SH: sel = addr_lo[1] ? SEL_HHI : SEL_HLO;
            OP_LW, OP_SW:         sel = SEL_W;
            default:              sel = 4'b0000;
        endcase
    end

    // Store data replicated onto all lanes so the RAM only needs the lane enables.
    always_comb begin
        lane_wdata = 32'h0;
        case (op)
            OP_SB:   lane_wdata = {4{wdata[7:0]}};
            OP_SH:   lane_wdata = {2{wdata[15:0]}};
            OP_SW:   lane_wdata = wdata;
            default: lane_wdata = 32'h0;
        endcase
    end

    // Load extension; the RAM already right-justifies the selected lanes.
    always_comb begin
        load_data = 32'h0;
        case (op)
            OP_LB:   load_data = {{24{rdata[7]}}, rdata[7:0]};
            OP_LBU:  load_data = {24'h0, rdata[7:0]};
            OP_LH:   load_data = {{16{rdata[15]}}, rdata[15:0]};
            OP_LHU:  load_data = {16'h0, rdata[15:0]};
            OP_LW:   load_data = rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store controller in front of the data RAM.
// Accepts one request at a time, drives a single RAM access cycle, hides the RAM's
// one-cycle read latency and returns a one-cycle registered response.
// Define MEM_MISALIGN_EXC_EN to trap misaligned halfword/word accesses instead of
// silently aligning them; without it exc_misalign/exc_badaddr are tied to 0.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              exc_misalign,
    output logic [31:0]       exc_badaddr,
    output logic              ram_rw,
    output logic [3:0]        ram_sel,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out
);

    state_t            state_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [3:0]        lane_sel;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_ext;
    logic [1:0]        accept_lo;

    // Address bits above ADDR_W alias and are deliberately dropped.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W];

`ifdef MEM_MISALIGN_EXC_EN
    // Misaligned requests never reach the latch, so the offset is kept as given.
    assign accept_lo = req_addr[1:0];
`else
    assign accept_lo = align_lo(req_op, req_addr[1:0]);
    assign exc_misalign = 1'b0;
    assign exc_badaddr  = 32'h0;
`endif

    // Ready is gated by rst so it reads 0 during every reset cycle.
    assign req_ready = (state_q == StIdle) && !rst;

    mem_lane_align u_lane_align (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (ram_data_out),
        .sel        (lane_sel),
        .lane_wdata (lane_wdata),
        .load_data  (load_ext)
    );

    // RAM-side outputs are live only in ACCESS, driven from the latched request.
    always_comb begin
        ram_rw      = 1'b0;
        ram_sel     = 4'b0000;
        ram_addr    = '0;
        ram_data_in = 32'h0;
        if (state_q == StAccess) begin
            ram_rw      = op_q[3];
            ram_sel     = lane_sel;
            ram_addr    = addr_q[ADDR_W-1:2];
            ram_data_in = op_q[3] ? lane_wdata : 32'h0;
        end
    end

    // Request FSM: latch accepted requests and produce the registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= 4'h0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
`ifdef MEM_MISALIGN_EXC_EN
            exc_misalign <= 1'b0;
            exc_badaddr  <= 32'h0;
`endif
        end else begin
            // Response outputs are single-cycle pulses.
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
`ifdef MEM_MISALIGN_EXC_EN
            exc_misalign <= 1'b0;
            exc_badaddr  <= 32'h0;
`endif
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (!op_legal(req_op)) begin
                            // Illegal op: answer immediately without touching the RAM.
                            rsp_valid <= 1'b1;
`ifdef MEM_MISALIGN_EXC_EN
                        end else if (op_misaligned(req_op, req_addr[1:0])) begin
                            rsp_valid    <= 1'b1;
                            exc_misalign <= 1'b1;
                            exc_badaddr  <= req_addr;
`endif
                        end else begin
                            op_q    <= req_op;
                            addr_q  <= {req_addr[ADDR_W-1:2], accept_lo};
                            wdata_q <= req_wdata;
                            state_q <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    if (op_q[3]) begin
                        // Store completes as the RAM writes at the end of this cycle.
                        rsp_valid <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_ext;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-array reference model predicts, per cycle, the
// response pulses, RAM-side outputs and req_ready; a simple RAM returns right-justified
// read data. Directed cases pin the model with literal values, then random traffic runs.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        exc_misalign;
    logic [31:0] exc_badaddr;
    logic        ram_rw;
    logic [3:0]  ram_sel;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(
        .ADDR_W (12),
        .RAM_AW (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .exc_misalign (exc_misalign),
        .exc_badaddr  (exc_badaddr),
        .ram_rw       (ram_rw),
        .ram_sel      (ram_sel),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- RAM: registered read, right-justified and zero-filled ----------------
    logic [31:0] ram [1024];

    function automatic logic [31:0] ram_read(input logic [31:0] w, input logic [3:0] sel);
        logic [31:0] m;
        int sh;
        m  = 32'h0;
        sh = 0;
        for (int i = 3; i >= 0; i--) begin
            if (sel[i]) begin
                m[8*i +: 8] = w[8*i +: 8];
                sh = i;
            end
        end
        return m >> (8 * sh);
    endfunction

    always_ff @(posedge clk) begin
        if (ram_rw) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_sel[i]) ram[ram_addr][8*i +: 8] <= ram_data_in[8*i +: 8];
            end
        end
        ram_data_out <= (!ram_rw && ram_sel != 4'd0) ? ram_read(ram[ram_addr], ram_sel)
                                                      : 32'hA5A5_5A5A;
    end

    // ---------------- reference model and per-cycle compare ----------------
    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        ex;
        logic [31:0] bad;
        logic        rw;
        logic [3:0]  sel;
        logic [9:0]  addr;
        logic [31:0] din;
    } exp_t;

    exp_t       ev [8];
    logic [7:0] mem [4096];

    initial begin : model_chk
        int          k;
        int          ready_at;
        int          s;
        int          s1;
        int          size;
        int          base;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] val;
        logic        store;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) ev[i] = '{default: 0};
        k        = 0;
        ready_at = 0;
        forever begin
            @(negedge clk);
            s = k % 8;
            if (rst) begin
                chk("ready_in_rst", 32'(req_ready), 32'd0);
                for (int i = 0; i < 8; i++) ev[i] = '{default: 0};
                ready_at = k + 1;
            end else begin
                chk("rsp_valid", 32'(rsp_valid), 32'(ev[s].rv));
                chk("rsp_rdata", rsp_rdata, ev[s].rd);
                chk("exc_misalign", 32'(exc_misalign), 32'(ev[s].ex));
                chk("exc_badaddr", exc_badaddr, ev[s].bad);
                chk("ram_rw", 32'(ram_rw), 32'(ev[s].rw));
                chk("ram_sel", 32'(ram_sel), 32'(ev[s].sel));
                chk("ram_addr", 32'(ram_addr), 32'(ev[s].addr));
                if (ev[s].rw || ev[s].sel == 4'd0) chk("ram_data_in", ram_data_in, ev[s].din);
                chk("req_ready", 32'(req_ready), 32'(k >= ready_at));
                if (req_valid && k >= ready_at) begin
                    a     = req_addr;
                    wd    = req_wdata;
                    store = (req_op == OP_SB || req_op == OP_SH || req_op == OP_SW);
                    case (req_op)
                        OP_LB, OP_LBU, OP_SB: size = 1;
                        OP_LH, OP_LHU, OP_SH: size = 2;
                        OP_LW, OP_SW:         size = 4;
                        default:              size = 0;
                    endcase
                    s1 = (k + 1) % 8;
                    if (size == 0) begin
                        ev[s1].rv = 1'b1;
                        ready_at  = k + 1;
                    end
`ifdef MEM_MISALIGN_EXC_EN
                    else if ((a % 32'(size)) != 32'd0) begin
                        ev[s1].rv  = 1'b1;
                        ev[s1].ex  = 1'b1;
                        ev[s1].bad = a;
                        ready_at   = k + 1;
                    end
`endif
                    else begin
                        a           = a - (a % 32'(size));
                        base        = int'(a % 32'd4096);
                        ev[s1].rw   = store;
                        ev[s1].sel  = 4'(((1 << size) - 1) << (base % 4));
                        ev[s1].addr = 10'(base / 4);
                        if (store) begin
                            for (int i = 0; i < 4; i++)
                                ev[s1].din[8*i +: 8] = wd[8*(i % size) +: 8];
                            for (int j = 0; j < size; j++) mem[base + j] = wd[8*j +: 8];
                            ev[(k + 2) % 8].rv = 1'b1;
                            ready_at = k + 2;
                        end else begin
                            val = 32'h0;
                            for (int j = 0; j < size; j++)
                                val = val | (32'(mem[base + j]) << (8 * j));
                            if ((req_op == OP_LB || req_op == OP_LH) && val[8*size-1])
                                for (int j = size; j < 4; j++) val[8*j +: 8] = 8'hFF;
                            ev[(k + 3) % 8].rv = 1'b1;
                            ev[(k + 3) % 8].rd = val;
                            ready_at = k + 3;
                        end
                    end
                end
            end
            ev[s] = '{default: 0};
            k++;
        end
    end

    // ---------------- monitor: record responses and RAM activity for literal pins ----------------
    typedef struct {
        logic [31:0] rd;
        logic        ex;
        logic [31:0] bad;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        rw;
        logic [3:0]  sel;
        logic [9:0]  addr;
        logic [31:0] din;
    } ram_t;

    rsp_t rsp_q [$];
    ram_t ram_q [$];

    initial begin : monitor
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rsp_valid) rsp_q.push_back('{rsp_rdata, exc_misalign, exc_badaddr, c});
                if (ram_rw || ram_sel != 4'd0)
                    ram_q.push_back('{ram_rw, ram_sel, ram_addr, ram_data_in});
            end
            c++;
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        logic got;
        int   n;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        got       = 1'b0;
        n         = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accepted", 32'(got), 32'd1);
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flush();
        idle(5);
        rsp_q.delete();
        ram_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] legal_ops [8];
    logic [3:0] bad_ops   [8];

    initial begin : main
        legal_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        bad_ops   = '{4'h3, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_ram_sel", 32'(ram_sel), 32'd0);
        @(posedge clk);
        #1;

        // Give the exercised RAM window known contents.
        for (int i = 0; i < 16; i++) issue(OP_SW, 32'(i * 4), 32'h0);

        // SW then LW at 0x010.
        flush();
        issue(OP_SW, 32'h010, 32'hDEAD_BEEF);
        issue(OP_LW, 32'h010, 32'h0);
        idle(5);
        chk("d1_nram", 32'(ram_q.size()), 32'd2);
        if (ram_q.size() >= 1) begin
            chk("d1_sw_rw", 32'(ram_q[0].rw), 32'd1);
            chk("d1_sw_sel", 32'(ram_q[0].sel), 32'hF);
            chk("d1_sw_addr", 32'(ram_q[0].addr), 32'd4);
            chk("d1_sw_data", ram_q[0].din, 32'hDEAD_BEEF);
        end
        chk("d1_nrsp", 32'(rsp_q.size()), 32'd2);
        if (rsp_q.size() >= 2) chk("d1_lw_rdata", rsp_q[1].rd, 32'hDEAD_BEEF);

        // SB 0x013 then LB / LBU.
        flush();
        issue(OP_SB, 32'h013, 32'h0000_00F0);
        issue(OP_LB, 32'h013, 32'h0);
        issue(OP_LBU, 32'h013, 32'h0);
        idle(5);
        if (ram_q.size() >= 1) begin
            chk("d2_sb_sel", 32'(ram_q[0].sel), 32'h8);
            chk("d2_sb_data", ram_q[0].din, 32'hF0F0_F0F0);
        end
        chk("d2_nrsp", 32'(rsp_q.size()), 32'd3);
        if (rsp_q.size() >= 3) begin
            chk("d2_lb", rsp_q[1].rd, 32'hFFFF_FFF0);
            chk("d2_lbu", rsp_q[2].rd, 32'h0000_00F0);
        end

        // SH 0x022 then LH / LHU.
        flush();
        issue(OP_SH, 32'h022, 32'h0000_8001);
        issue(OP_LH, 32'h022, 32'h0);
        issue(OP_LHU, 32'h022, 32'h0);
        idle(5);
        if (ram_q.size() >= 1) chk("d3_sh_sel", 32'(ram_q[0].sel), 32'hC);
        chk("d3_nrsp", 32'(rsp_q.size()), 32'd3);
        if (rsp_q.size() >= 3) begin
            chk("d3_lh", rsp_q[1].rd, 32'hFFFF_8001);
            chk("d3_lhu", rsp_q[2].rd, 32'h0000_8001);
        end

        // Misaligned LW at 0x011.
        flush();
        issue(OP_LW, 32'h011, 32'h0);
        idle(5);
        chk("d4_nrsp", 32'(rsp_q.size()), 32'd1);
`ifdef MEM_MISALIGN_EXC_EN
        chk("d4_nram", 32'(ram_q.size()), 32'd0);
        if (rsp_q.size() >= 1) begin
            chk("d4_exc", 32'(rsp_q[0].ex), 32'd1);
            chk("d4_badaddr", rsp_q[0].bad, 32'h0000_0011);
            chk("d4_rdata", rsp_q[0].rd, 32'h0);
        end
`else
        chk("d4_nram", 32'(ram_q.size()), 32'd1);
        if (ram_q.size() >= 1) begin
            chk("d4_addr", 32'(ram_q[0].addr), 32'd4);
            chk("d4_rw", 32'(ram_q[0].rw), 32'd0);
        end
        if (rsp_q.size() >= 1) chk("d4_rdata", rsp_q[0].rd, 32'hF0AD_BEEF);
`endif

        // Reset during the WAIT cycle of a load.
        flush();
        issue(OP_LW, 32'h010, 32'h0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        chk("d5_ready", 32'(req_ready), 32'd1);
        chk("d5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("d5_rdata", rsp_rdata, 32'h0);
        chk("d5_ram_sel", 32'(ram_sel), 32'd0);
        chk("d5_ram_rw", 32'(ram_rw), 32'd0);
        @(posedge clk);
        #1;
        idle(4);
        chk("d5_nrsp", 32'(rsp_q.size()), 32'd0);

        // Illegal op followed by back-to-back stores.
        flush();
        issue(4'h3, 32'h004, 32'h1234_5678);
        issue(OP_SW, 32'h000, 32'h1111_2222);
        issue(OP_SW, 32'h004, 32'h3333_4444);
        idle(5);
        chk("d6_nrsp", 32'(rsp_q.size()), 32'd3);
        chk("d6_nram", 32'(ram_q.size()), 32'd2);
        if (rsp_q.size() >= 3) begin
            chk("d6_ill_rdata", rsp_q[0].rd, 32'h0);
            chk("d6_gap1", 32'(rsp_q[1].cyc - rsp_q[0].cyc), 32'd2);
            chk("d6_gap2", 32'(rsp_q[2].cyc - rsp_q[1].cyc), 32'd2);
        end

        // Random traffic in a 16-word window with random aliasing upper bits.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 11) == 0)
                issue(bad_ops[$urandom_range(0, 7)], $urandom & 32'hFFFF_F03F, $urandom);
            else
                issue(legal_ops[$urandom_range(0, 7)], $urandom & 32'hFFFF_F03F, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store controller sitting directly upstream of the data RAM. It accepts one load or store request at a time from the MEM pipeline stage, converts the byte address into a RAM word address and byte-lane select, replicates store data onto lanes, and sign- or zero-extends returned load data. It also absorbs the RAM's one-cycle registered read latency behind a valid/ready handshake that stalls the pipeline.

## Interface
- ADDR_W, 12: number of decoded byte-address bits; higher bits are ignored.
- RAM_AW, 10: RAM word-address width; must equal ADDR_W-2.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  4  LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8, SH=9, SW=A; other codes are illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores, exceptions and illegal ops
- exc_misalign  out  1  pulses with rsp_valid on a trapped misaligned access
- exc_badaddr  out  32  faulting address; valid while exc_misalign is high
- ram_rw  out  1  1 = write
- ram_sel  out  4  byte-lane enables
- ram_addr  out  RAM_AW  word address, req_addr[ADDR_W-1:2]
- ram_data_in  out  32  lane-replicated store data
- ram_data_out  in  32  RAM read data; the RAM returns it right-justified and zero-filled, registered one cycle after the request

## Operation
- FSM states:
  - IDLE: accepts a request on req_valid && req_ready and latches op, addr and wdata.
  - ACCESS: drives the RAM-side outputs from the latched request.
  - WAIT: loads only; samples and extends ram_data_out.
- FSM transitions:
  - IDLE→ACCESS on accept.
  - ACCESS→IDLE for stores.
  - ACCESS→WAIT for loads.
  - WAIT→IDLE.
- Lane select:
  - Byte ops: 4'b0001 << addr[1:0].
  - Halfword ops: addr[1] ? 4'b1100 : 4'b0011.
  - Word ops: 4'b1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extension:
  - LB sign-extends from bit 7; LBU zero-extends from bit 7.
  - LH sign-extends from bit 15; LHU zero-extends from bit 15.
  - LW passes the data through.
- Outside ACCESS, all RAM-side outputs are 0 (ram_rw=0, ram_sel=0).
- Illegal op: no RAM access. Goes IDLE→IDLE; rsp_valid pulses the next cycle with rsp_rdata=0.
- Addresses at or above 2^ADDR_W alias modulo 2^ADDR_W.

## Timing
- Accept at cycle T.
  - Store: ram_rw=1 during T+1 and the RAM writes at the end of T+1. rsp_valid is high in T+2; req_ready is high again in T+2.
  - Load: the read is issued in T+1. ram_data_out is valid in T+2 and is registered at the end of T+2. rsp_valid and rsp_rdata are valid in T+3; req_ready is high in T+3.
- Throughput: one store per 2 cycles, one load per 3 cycles.
- rsp_valid, rsp_rdata, exc_misalign and exc_badaddr are registered outputs and hold for exactly one cycle.
- Reset values: all outputs 0, including req_ready during the rst cycle. State is IDLE.
- Reset mid-operation drops the in-flight request. No rsp_valid is issued for it, and RAM-side outputs are 0 from the next cycle.
- req_valid while not ready is ignored. The requester holds the request until it is accepted.

## Configuration
- MEM_MISALIGN_EXC_EN, defined:
  - Misaligned accesses are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0.
  - These do no RAM access. At T+1, rsp_valid=1, rsp_rdata=0, exc_misalign=1, exc_badaddr=req_addr.
  - State stays IDLE.
- MEM_MISALIGN_EXC_EN, undefined:
  - Low address bits are forced to alignment: halfword ops clear addr[0], word ops clear addr[1:0].
  - The access proceeds normally.
  - exc_misalign and exc_badaddr are tied to 0.

## Structure
- Package mem_access_pkg holds:
  - op-code constants;
  - FSM state enum;
  - lane-select constants SEL_B0..SEL_B3, SEL_HLO, SEL_HHI, SEL_W.
- One sub-module, mem_lane_align (combinational). It takes op and addr[1:0] and produces ram_sel, ram_data_in and the extended load result. It contains no state.

## Test plan
- SW addr 0x010, data 0xDEADBEEF, then LW addr 0x010:
  - during the store's ACCESS cycle, ram_addr=4, ram_sel=1111, ram_rw=1;
  - the load returns rsp_rdata=0xDEADBEEF three cycles after its accept.
- SB addr 0x013, data 0x000000F0:
  - ram_sel=1000, ram_data_in=0xF0F0F0F0;
  - a following LB at 0x013 returns 0xFFFFFFF0, and LBU returns 0x000000F0.
- SH addr 0x022, data 0x8001:
  - ram_sel=1100;
  - LH at 0x022 returns 0xFFFF8001, and LHU returns 0x00008001.
- LW addr 0x011:
  - with the macro: exc_misalign=1, exc_badaddr=0x11 and no RAM activity;
  - without the macro: reads word address 4.
- rst asserted in the WAIT cycle of a load: no rsp_valid, all outputs 0, and req_ready=1 in the first cycle after rst deasserts.
- Illegal op 4'h3, then back-to-back SW/SW: rsp_valid pulses for each request, and req_ready toggles with 2-cycle spacing.
